frame_accum_16bit: RTL and testbench
====================================

Name: frame_accum_16bit

Overview:
- Sequential operand stage that accumulates a framed stream of 16-bit operands into one 16-bit sum, with a ripple-style add and carry-out per step.
- Sits directly upstream of the result consumer and feeds it.
- Input and output both use valid/ready handshakes.
- Each frame ends with in_last; the frame's sum, carry-out count and operand count appear as one output beat.

Parameters:
- WIDTH, 16, operand and sum width.
- CNT_W, 8, width of operand counter and carry-out counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  stage can accept an operand.
- in_data  input  WIDTH  operand.
- in_last  input  1  marks the final operand of a frame.
- out_valid  output  1  frame result valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  WIDTH  frame sum, modulo 2^WIDTH.
- out_ovf_cnt  output  CNT_W  number of carry-outs during the frame; saturates at all-ones.
- out_count  output  CNT_W  operands in the frame; saturates at all-ones.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low.
- Reset values: out_valid=0, out_sum=0, out_ovf_cnt=0, out_count=0, acc=0, ovf=0, cnt=0, state=EMPTY. in_ready evaluates to 1 after reset.
- Accept and complete:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_ready = ~out_valid | out_ready. This gives full throughput when the consumer is always ready.
- Adder:
  - sum_n = acc + in_data, a WIDTH-bit add with carry c.
  - ovf_n = ovf + c, saturating.
  - cnt_n = cnt + 1, saturating.
- FSM state EMPTY (no partial frame; acc, ovf and cnt all 0):
  - in_fire with in_last=0: acc<=sum_n, ovf<=ovf_n, cnt<=cnt_n; go to PARTIAL.
  - in_fire with in_last=1: load the output registers from sum_n, ovf_n and cnt_n; out_valid<=1; stay in EMPTY.
- FSM state PARTIAL:
  - in_fire with in_last=0: update acc, ovf and cnt.
  - in_fire with in_last=1: load the output registers; clear acc, ovf and cnt; go to EMPTY.
- Output register:
  - out_fire with no new load: out_valid<=0.
  - Load and out_fire in the same cycle: the new result replaces the old one and out_valid stays 1. No beat is lost or duplicated.
  - Output fields are held stable while out_valid=1 and out_ready=0.
- Latency: the result is visible the cycle after the last operand is accepted.
- Frame boundaries:
  - A single-operand frame gives out_sum=in_data, out_count=1, out_ovf_cnt=0.
  - in_valid=0 cycles inside a frame are ignored; the partial state is held.
- Reset asserted mid-frame or mid-hold discards the partial sum and any pending result immediately (asynchronously). Nothing is emitted.
- X on in_data or in_last while in_valid=0 must not affect state.

Optional Feature:
- Macro: FRAME_ACCUM_SAT_EN.
- Defined:
  - Sum saturates: if c=1, or ovf was already nonzero, sum_n is forced to all-ones.
  - out_ovf_cnt behaviour is unchanged.
- Undefined: the sum wraps modulo 2^WIDTH as described above.
- Handshake and timing are identical in both builds.

Test Plan:
- Frame 0x0001, 0x0002, 0x0003(last), out_ready=1 -> one beat, 1 cycle after the last accept: sum=0x0006, count=3, ovf_cnt=0.
- Frame 0xFFFF, 0x0002(last) -> sum=0x0001, ovf_cnt=1, count=2. With FRAME_ACCUM_SAT_EN: sum=0xFFFF.
- Back-to-back single-operand frames 0x1234(last), 0xABCD(last), out_ready=1 -> in_ready stays 1; out_valid is high 2 consecutive cycles with sums 0x1234 then 0xABCD.
- out_ready=0 while a result is pending, then a new last operand arrives -> in_ready=0; the result is held unchanged. Raising out_ready completes the old beat and accepts the new operand in the same cycle. The next beat carries the new frame.
- 300 operands of 0x0100 in one frame, CNT_W=8 -> count saturates at 0xFF; sum=(300*0x100) mod 2^16=0x2C00; ovf_cnt=1.
- Drive 0x0005, 0x0006, then assert rst_n=0 mid-cycle, release, then send 0x0007(last) -> outputs are 0 during reset; the next beat is sum=0x0007, count=1.

Source files
------------

// File: rtl/frame_accum_16bit.sv
// frame_accum_16bit
//   Accumulates a framed stream of operands into a single sum. Each operand
//   is added with a ripple add; the carry-out of every add is counted. When
//   the operand flagged in_last is accepted, the frame's sum, carry-out count
//   and operand count are presented as one output beat on a valid/ready port.
//
//   Build option: define FRAME_ACCUM_SAT_EN to make the sum saturate at
//   all-ones once any carry-out has occurred in the frame. Without it the sum
//   wraps modulo 2^WIDTH. Handshake and timing are the same in both builds.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     operand beat valid
//   in_ready     stage can accept an operand
//   in_data      operand [WIDTH]
//   in_last      final operand of the frame
//   out_valid    frame result valid
//   out_ready    consumer accepts the result
//   out_sum      frame sum [WIDTH]
//   out_ovf_cnt  carry-outs in the frame, saturating [CNT_W]
//   out_count    operands in the frame, saturating [CNT_W]
module frame_accum_16bit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0] out_ovf_cnt,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic {S_EMPTY = 1'b0, S_PARTIAL = 1'b1} state_t;

  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic             inc);
    if (&v) return v;
    return v + CNT_W'(inc);
  endfunction

  function automatic logic [WIDTH-1:0] f_sum_next(input logic [WIDTH-1:0] raw,
                                                  input logic             c,
                                                  input logic             ovf_seen);
`ifdef FRAME_ACCUM_SAT_EN
    if (c || ovf_seen) return '1;
    return raw;
`else
    // Wrapping build: carry is only counted, never folded into the sum.
    if (c && ovf_seen) return raw;
    return raw;
`endif
  endfunction

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_ovf;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_sum;
  logic [CNT_W-1:0] r_out_ovf;
  logic [CNT_W-1:0] r_out_cnt;

  logic             w_in_ready;
  logic             w_in_fire;
  logic             w_out_fire;
  logic [WIDTH-1:0] w_sum_raw;
  logic             w_carry;
  logic [WIDTH-1:0] w_sum_n;
  logic [CNT_W-1:0] w_ovf_n;
  logic [CNT_W-1:0] w_cnt_n;
  logic             w_load;
  logic             w_acc_upd;
  logic             w_acc_clr;

  // Ready is combinational from out_ready so a held result can drain and be
  // replaced in the same cycle (full throughput with an always-ready consumer).
  assign w_in_ready = ~r_out_valid | out_ready;
  assign w_in_fire  = in_valid & w_in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  assign {w_carry, w_sum_raw} = {1'b0, r_acc} + {1'b0, in_data};
  assign w_sum_n = f_sum_next(w_sum_raw, w_carry, |r_ovf);
  assign w_ovf_n = f_sat_inc(r_ovf, w_carry);
  assign w_cnt_n = f_sat_inc(r_cnt, 1'b1);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    if (w_in_fire) begin
      if (in_last) w_state_nxt = S_EMPTY;
      else         w_state_nxt = S_PARTIAL;
    end
  end

  // FSM: outputs (datapath controls)
  always_comb begin
    w_load    = 1'b0;
    w_acc_upd = 1'b0;
    w_acc_clr = 1'b0;
    if (w_in_fire) begin
      if (in_last) begin
        w_load    = 1'b1;
        // EMPTY already holds zeros; only a partial frame needs clearing.
        w_acc_clr = (r_state == S_PARTIAL);
      end else begin
        w_acc_upd = 1'b1;
      end
    end
  end

  // Stage 0 -> accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_ovf <= '0;
      r_cnt <= '0;
    end else if (w_acc_clr) begin
      r_acc <= '0;
      r_ovf <= '0;
      r_cnt <= '0;
    end else if (w_acc_upd) begin
      r_acc <= w_sum_n;
      r_ovf <= w_ovf_n;
      r_cnt <= w_cnt_n;
    end
  end

  // Stage 1 -> output register; a load wins over a drain so no beat is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_ovf   <= '0;
      r_out_cnt   <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_sum   <= w_sum_n;
      r_out_ovf   <= w_ovf_n;
      r_out_cnt   <= w_cnt_n;
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_out_valid;
  assign out_sum     = r_out_sum;
  assign out_ovf_cnt = r_out_ovf;
  assign out_count   = r_out_cnt;

endmodule

// File: tb/tb_frame_accum_16bit.sv
module tb_frame_accum_16bit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic [7:0]  out_ovf_cnt;
  logic [7:0]  out_count;

  int n_vec = 0;
  int n_err = 0;

  frame_accum_16bit #(.WIDTH(16), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_ovf_cnt (out_ovf_cnt),
    .out_count   (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand for exactly one edge (caller guarantees in_ready).
  task automatic push(input logic [15:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_data  = 'x;
    in_last  = 1'bx;
  endtask

  task automatic chk_beat(input string tag, input logic [15:0] s,
                          input logic [7:0] o, input logic [7:0] c);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".sum"},   {16'd0, out_sum},   {16'd0, s});
    chk({tag, ".ovf"},   {24'd0, out_ovf_cnt}, {24'd0, o});
    chk({tag, ".cnt"},   {24'd0, out_count}, {24'd0, c});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 'x;
    in_last   = 1'bx;
    out_ready = 1'b1;
    #1;
    chk("rst.valid", {31'd0, out_valid}, 32'd0);
    chk("rst.sum",   {16'd0, out_sum}, 32'd0);
    chk("rst.ovf",   {24'd0, out_ovf_cnt}, 32'd0);
    chk("rst.cnt",   {24'd0, out_count}, 32'd0);
    chk("rst.ready", {31'd0, in_ready}, 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Three-operand frame; result appears right after the last accept.
    push(16'h0001, 1'b0);
    push(16'h0002, 1'b0);
    chk("f1.novalid", {31'd0, out_valid}, 32'd0);
    push(16'h0003, 1'b1);
    chk_beat("f1", 16'h0006, 8'd0, 8'd3);
    tick();
    chk("f1.drain", {31'd0, out_valid}, 32'd0);

    // Carry-out frame.
    push(16'hFFFF, 1'b0);
    push(16'h0002, 1'b1);
`ifdef FRAME_ACCUM_SAT_EN
    chk_beat("f2", 16'hFFFF, 8'd1, 8'd2);
`else
    chk_beat("f2", 16'h0001, 8'd1, 8'd2);
`endif
    tick();

    // Back-to-back single-operand frames.
    in_valid = 1'b1;
    in_data  = 16'h1234;
    in_last  = 1'b1;
    tick();
    chk_beat("b2b0", 16'h1234, 8'd0, 8'd1);
    chk("b2b0.ready", {31'd0, in_ready}, 32'd1);
    in_data = 16'hABCD;
    tick();
    chk_beat("b2b1", 16'hABCD, 8'd0, 8'd1);
    in_valid = 1'b0;
    in_data  = 'x;
    in_last  = 1'bx;
    tick();
    chk("b2b.drain", {31'd0, out_valid}, 32'd0);

    // Backpressure: held result, then drain and reload in one cycle.
    out_ready = 1'b0;
    push(16'h0011, 1'b1);
    chk_beat("bp.first", 16'h0011, 8'd0, 8'd1);
    in_valid = 1'b1;
    in_data  = 16'h0022;
    in_last  = 1'b1;
    #1;
    chk("bp.ready0", {31'd0, in_ready}, 32'd0);
    tick();
    chk_beat("bp.hold1", 16'h0011, 8'd0, 8'd1);
    tick();
    chk_beat("bp.hold2", 16'h0011, 8'd0, 8'd1);
    out_ready = 1'b1;
    #1;
    chk("bp.ready1", {31'd0, in_ready}, 32'd1);
    tick();
    chk_beat("bp.new", 16'h0022, 8'd0, 8'd1);
    in_valid = 1'b0;
    in_data  = 'x;
    in_last  = 1'bx;
    tick();
    chk("bp.drain", {31'd0, out_valid}, 32'd0);

    // Idle cycles inside a frame (inputs X while in_valid=0).
    push(16'h0010, 1'b0);
    tick();
    tick();
    chk("idle.novalid", {31'd0, out_valid}, 32'd0);
    push(16'h0020, 1'b1);
    chk_beat("idle", 16'h0030, 8'd0, 8'd2);
    tick();

    // Long frame: operand count saturates.
    for (int i = 0; i < 299; i++) push(16'h0100, 1'b0);
    push(16'h0100, 1'b1);
`ifdef FRAME_ACCUM_SAT_EN
    // Once saturated at 0xFFFF every further add carries: 1 + 44 carry-outs.
    chk_beat("long", 16'hFFFF, 8'd45, 8'hFF);
`else
    chk_beat("long", 16'h2C00, 8'd1, 8'hFF);
`endif
    tick();

    // Asynchronous reset mid-frame discards the partial sum.
    push(16'h0005, 1'b0);
    push(16'h0006, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst.valid", {31'd0, out_valid}, 32'd0);
    chk("mrst.sum",   {16'd0, out_sum}, 32'd0);
    chk("mrst.cnt",   {24'd0, out_count}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    push(16'h0007, 1'b1);
    chk_beat("mrst.after", 16'h0007, 8'd0, 8'd1);
    tick();
    chk("end.drain", {31'd0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
